// File: rtl/register_file_p.sv
// register_file_p: multi-ported register file with a power-on/clear sweep.
// After reset, or when asked, a sweep rewrites every register with its init value,
// one register per cycle. During the sweep the reads return 0 and writes are refused.
// Register 0 always reads as 0. An optional forwarding path lets a read see the
// data being written in the same cycle.
module register_file_p #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int AW        = $clog2(NREG),
    parameter int INIT_MODE = 1,
    parameter int BYPASS    = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] register_data,
    input  logic            wer,
    input  logic            clear_req,
    output logic [XLEN-1:0] rs1_value,
    output logic [XLEN-1:0] rs2_value,
    output logic            ready,
    output logic [AW-1:0]   clr_ptr
);

    localparam logic [0:0]    ST_CLEAR = 1'b0;
    localparam logic [0:0]    ST_IDLE  = 1'b1;
    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    logic [0:0]      state_q, state_d;
    logic [AW-1:0]   clr_ptr_q, clr_ptr_d;
    logic            regs_we;
    logic [AW-1:0]   regs_waddr;
    logic [XLEN-1:0] regs_wdata;
    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] rs1_raw, rs2_raw;

    // Value a register receives when the sweep reaches it.
    function automatic logic [XLEN-1:0] init_value(input logic [AW-1:0] idx);
        if (INIT_MODE != 0) begin
            return XLEN'(idx);
        end
        return '0;
    endfunction

    // Read-port resolution: outputs are forced to 0 while sweeping and for x0.
    // Forwarding is qualified with ready, so a write that is about to be
    // dropped is never forwarded during a sweep.
    function automatic logic [XLEN-1:0] read_port(
        input logic [AW-1:0]   rs,
        input logic [XLEN-1:0] stored,
        input logic            idle,
        input logic            we,
        input logic [AW-1:0]   waddr,
        input logic [XLEN-1:0] wdata
    );
        if (!idle || rs == '0) begin
            return '0;
        end
        if (BYPASS != 0 && we && waddr != '0 && waddr == rs) begin
            return wdata;
        end
        return stored;
    endfunction

    // Next-state logic: sweep progression, clear entry, and selection of the storage write.
    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        regs_we    = 1'b0;
        regs_waddr = clr_ptr_q;
        regs_wdata = init_value(clr_ptr_q);
        case (state_q)
            ST_CLEAR: begin
                regs_we = 1'b1;
                if (clr_ptr_q == LAST_IDX) begin
                    state_d   = ST_IDLE;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            default: begin
                if (clear_req) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = '0;
                end else if (wer && rd != '0) begin
                    regs_we    = 1'b1;
                    regs_waddr = rd;
                    regs_wdata = register_data;
                end
            end
        endcase
    end

    // Control state: async reset puts the block straight back into a sweep from register 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Storage: no reset; writes are suppressed while rst_n is low so an aborted operation leaves no trace.
    always_ff @(posedge clk) begin
        if (regs_we && rst_n) begin
            regs_q[regs_waddr] <= regs_wdata;
        end
    end

    assign rs1_raw   = regs_q[rs1];
    assign rs2_raw   = regs_q[rs2];
    assign ready     = (state_q == ST_IDLE);
    assign clr_ptr   = clr_ptr_q;
    assign rs1_value = read_port(rs1, rs1_raw, ready, wer, rd, register_data);
    assign rs2_value = read_port(rs2, rs2_raw, ready, wer, rd, register_data);

endmodule

// File: tb/tb_register_file_p.sv
// tb_register_file_p: drives two register files (INIT_MODE=1/BYPASS=1 and
// INIT_MODE=0/BYPASS=0) with the same stimulus. A behavioural model predicts
// every output each cycle; the predictions are queued and a separate monitor
// compares them on the falling edge.
module tb_register_file_p;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] register_data;
    logic        wer, clear_req;
    logic [31:0] rs1_a, rs2_a, rs1_b, rs2_b;
    logic        ready_a, ready_b;
    logic [4:0]  ptr_a, ptr_b;

    register_file_p #(.XLEN(32), .NREG(32), .INIT_MODE(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .rd(rd),
        .register_data(register_data), .wer(wer), .clear_req(clear_req),
        .rs1_value(rs1_a), .rs2_value(rs2_a), .ready(ready_a), .clr_ptr(ptr_a)
    );

    register_file_p #(.XLEN(32), .NREG(32), .INIT_MODE(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .rd(rd),
        .register_data(register_data), .wer(wer), .clear_req(clear_req),
        .rs1_value(rs1_b), .rs2_value(rs2_b), .ready(ready_b), .clr_ptr(ptr_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] r1a, r2a, r1b, r2b;
        logic        rdy_a, rdy_b;
        logic [4:0]  ptr_a, ptr_b;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    errors = 0;
    int    checks = 0;

    // Reference model: index 0 = INIT_MODE 1 / bypass on, index 1 = INIT_MODE 0 / bypass off.
    // m_sweep < 0 means idle; otherwise it is the register the sweep writes next.
    logic [31:0] m_regs [2][32];
    int          m_sweep [2];

    function automatic logic [31:0] m_read(input int k, input logic [4:0] rs);
        if (m_sweep[k] >= 0) return 32'h0;
        if (rs == 5'd0) return 32'h0;
        if (k == 0 && wer && rd != 5'd0 && rd == rs) return register_data;
        return m_regs[k][rs];
    endfunction

    task automatic m_edge();
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_sweep[k] = 0;
            end else if (m_sweep[k] >= 0) begin
                m_regs[k][m_sweep[k]] = (k == 0) ? 32'(m_sweep[k]) : 32'h0;
                m_sweep[k] = m_sweep[k] + 1;
                if (m_sweep[k] == 32) m_sweep[k] = -1;
            end else if (clear_req) begin
                m_sweep[k] = 0;
            end else if (wer && rd != 5'd0) begin
                m_regs[k][rd] = register_data;
            end
        end
    endtask

    // One cycle: apply inputs, queue the predicted outputs, clock the model.
    task automatic step(input logic rn, input logic w, input logic [4:0] a_rd,
                        input logic [31:0] dat, input logic clr,
                        input logic [4:0] a1, input logic [4:0] a2, input string nm);
        exp_t e;
        rst_n = rn; wer = w; rd = a_rd; register_data = dat; clear_req = clr;
        rs1 = a1; rs2 = a2;
        if (!rn) begin
            m_sweep[0] = 0;
            m_sweep[1] = 0;
        end
        e.r1a   = m_read(0, a1);
        e.r2a   = m_read(0, a2);
        e.r1b   = m_read(1, a1);
        e.r2b   = m_read(1, a2);
        e.rdy_a = (m_sweep[0] < 0);
        e.rdy_b = (m_sweep[1] < 0);
        e.ptr_a = (m_sweep[0] < 0) ? 5'd0 : 5'(m_sweep[0]);
        e.ptr_b = (m_sweep[1] < 0) ? 5'd0 : 5'(m_sweep[1]);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic idle_read(input logic [4:0] a1, input logic [4:0] a2, input string nm);
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, a1, a2, nm);
    endtask

    task automatic noise(input logic rn, input string nm);
        step(rn, 1'($urandom), 5'($urandom), $urandom, 1'($urandom),
             5'($urandom), 5'($urandom), nm);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    // Monitor: compares every queued prediction against the live outputs.
    always @(negedge clk) begin
        exp_t  e;
        string n;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            chk({n, ".rs1_a"},   rs1_a,           e.r1a);
            chk({n, ".rs2_a"},   rs2_a,           e.r2a);
            chk({n, ".rs1_b"},   rs1_b,           e.r1b);
            chk({n, ".rs2_b"},   rs2_b,           e.r2b);
            chk({n, ".ready_a"}, 32'(ready_a),    32'(e.rdy_a));
            chk({n, ".ready_b"}, 32'(ready_b),    32'(e.rdy_b));
            chk({n, ".ptr_a"},   32'(ptr_a),      32'(e.ptr_a));
            chk({n, ".ptr_b"},   32'(ptr_b),      32'(e.ptr_b));
        end
    end

    initial begin
        logic [4:0] r;
        logic [4:0] a1;
        for (int k = 0; k < 2; k++) begin
            m_sweep[k] = 0;
            for (int i = 0; i < 32; i++) m_regs[k][i] = 'x;
        end
        rst_n = 1'b0; wer = 1'b0; rd = '0; register_data = '0; clear_req = 1'b0;
        rs1 = '0; rs2 = '0;
        @(posedge clk);
        #1;

        // Reset held: outputs idle at 0, sweep pointer parked.
        repeat (3) noise(1'b0, "reset");

        // Power-up sweep with ignored writes/clears; a directed write to r12 mid-sweep.
        for (int i = 0; i < 32; i++) begin
            if (i == 5) step(1'b1, 1'b1, 5'd12, 32'h55, 1'b0, 5'd12, 5'd3, "wr_in_clear");
            else        noise(1'b1, "sweep");
        end
        idle_read(5'd5, 5'd31, "init_5_31");
        idle_read(5'd0, 5'd12, "init_0_12");

        // Write/readback and x0 protection.
        step(1'b1, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd7, 5'd1, "wr7");
        idle_read(5'd7, 5'd7, "rb7");
        step(1'b1, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 5'd0, "wr0");
        idle_read(5'd0, 5'd0, "rb0");

        // Same-cycle forwarding on both ports.
        step(1'b1, 1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, 5'd9, 5'd9, "byp9");
        idle_read(5'd9, 5'd9, "after9");

        // Clear request beats a simultaneous write.
        step(1'b1, 1'b1, 5'd3, 32'hFF, 1'b0, 5'd3, 5'd4, "wr3");
        step(1'b1, 1'b1, 5'd4, 32'h77, 1'b1, 5'd3, 5'd4, "clr_req");
        repeat (32) noise(1'b1, "clearing");
        idle_read(5'd3, 5'd4, "post_clr");

        // Reset in the middle of a sweep, at clr_ptr = 10.
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 5'd2, "clr2");
        repeat (10) noise(1'b1, "sweep2");
        noise(1'b0, "rst_mid");
        noise(1'b0, "rst_hold");
        repeat (32) noise(1'b1, "sweep3");
        for (int i = 0; i < 32; i++) idle_read(5'(i), 5'(31 - i), "readall");

        // Random traffic, including forwarding hits and occasional clears.
        for (int i = 0; i < 400; i++) begin
            r  = 5'($urandom);
            a1 = ($urandom_range(0, 3) == 0) ? r : 5'($urandom);
            step(1'b1, 1'($urandom), r, $urandom, ($urandom_range(0, 49) == 0),
                 a1, 5'($urandom), "random");
        end

        repeat (3) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/register_file_p.md
REGISTER_FILE_P -- requirements
Module: register_file_p

Interface
REQ-001 SHALL provide parameter XLEN, default 32, data width of each register.
REQ-002 SHALL provide parameter NREG, default 32, register count; power of two, at least 4.
REQ-003 SHALL provide parameter AW, default $clog2(NREG), register address width.
REQ-004 SHALL provide parameter INIT_MODE, default 1, init value: 0 = all zero, 1 = register i holds i.
REQ-005 SHALL provide parameter BYPASS, default 1, write-to-read forwarding: 1 = enabled, 0 = disabled.
REQ-006 SHALL have port clk, input, 1 bit: the only clock; all state changes on the rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port rs1, input, AW bits: read port 1 address.
REQ-009 SHALL have port rs2, input, AW bits: read port 2 address.
REQ-010 SHALL have port rd, input, AW bits: write address.
REQ-011 SHALL have port register_data, input, XLEN bits: write data.
REQ-012 SHALL have port wer, input, 1 bit: write enable.
REQ-013 SHALL have port clear_req, input, 1 bit: request to re-initialise all registers.
REQ-014 SHALL have port rs1_value, output, XLEN bits: read port 1 data.
REQ-015 SHALL have port rs2_value, output, XLEN bits: read port 2 data.
REQ-016 SHALL have port ready, output, 1 bit: high when the block is idle and accepting writes.
REQ-017 SHALL have port clr_ptr, output, AW bits: index of the register being initialised; 0 when idle.

Function
REQ-018 SHALL implement a two-state FSM with states CLEAR and IDLE; ready is 1 exactly when the state is IDLE.
REQ-019 In CLEAR, each rising edge SHALL write the init value to register clr_ptr and then increment clr_ptr.
  - Init value: 0 when INIT_MODE=0; clr_ptr zero-extended to XLEN when INIT_MODE=1.
REQ-020 On the edge where register NREG-1 is written, the FSM SHALL go to IDLE and clr_ptr SHALL wrap to 0.
  - The sweep therefore takes exactly NREG cycles.
REQ-021 In IDLE, clear_req=1 at a rising edge SHALL move the FSM to CLEAR with clr_ptr=0.
  - No register is written on that edge; any wer asserted on the same edge is dropped (clear has priority).
REQ-022 In CLEAR, wer and clear_req SHALL be ignored.
REQ-023 In IDLE, wer=1 with rd!=0 SHALL write register_data to register rd at the rising edge.
  - wer with rd=0 SHALL have no effect.
REQ-024 Reads SHALL be combinational (zero latency): rsN_value = register[rsN].
REQ-025 Any read with rsN=0 SHALL return 0 regardless of storage, state or bypass.
REQ-026 When BYPASS=1, ready=1, wer=1, rd!=0 and rd==rsN, rsN_value SHALL equal register_data in the same cycle.
  - rs1 and rs2 are forwarded independently.
REQ-027 When BYPASS=0, a write SHALL become visible on the read ports only after the rising edge that performs it.
REQ-028 While ready=0, both read ports SHALL return 0.
REQ-029 Register storage SHALL NOT use initial blocks; contents are defined only by the CLEAR sweep and by writes.

Reset
REQ-030 rst_n=0 SHALL immediately force state=CLEAR, clr_ptr=0 and ready=0; rs1_value and rs2_value then read 0.
REQ-031 Register contents SHALL NOT be reset directly; they are rewritten by the CLEAR sweep after rst_n rises.
REQ-032 rst_n asserted mid-sweep or mid-write SHALL abort the operation; after release the sweep restarts from clr_ptr=0.

Verification
REQ-033 Reset sweep, NREG=32, INIT_MODE=1:
  - Release rst_n, then count edges -> ready rises after exactly 32 rising edges.
  - Then rs1=5 -> 5; rs2=31 -> 31; rs1=0 -> 0.
REQ-034 Write and read-back with x0 protection:
  - wer=1, rd=7, data=0xDEADBEEF; next cycle rs1=7 -> 0xDEADBEEF.
  - wer=1, rd=0, data=0x1234 -> rs2=0 reads 0.
REQ-035 Bypass:
  - BYPASS=1, rs1=rs2=9, wer=1, rd=9, data=0xA5A5A5A5 -> both outputs 0xA5A5A5A5 in the same cycle.
  - BYPASS=0, same stimulus -> old value (9) until after the edge.
REQ-036 Clear request:
  - Write rd=3 with 0xFF, then clear_req=1 together with wer=1, rd=4, data=0x77.
  - Expect: ready=0 for 32 cycles, reads return 0 meanwhile, write dropped; afterwards rs1=3 -> 3 and rs2=4 -> 4.
REQ-037 Reset mid-sweep, INIT_MODE=0:
  - Assert rst_n=0 when clr_ptr=10 -> clr_ptr=0 and ready=0 immediately.
  - After release, ready rises 32 edges later and all registers read 0.
REQ-038 Writes during CLEAR:
  - wer=1, rd=12, data=0x55 while ready=0 -> after the sweep, rs1=12 reads 12 (INIT_MODE=1).
